// File: rtl/cpu_alu_pkg.sv
// rtl/cpu_alu_pkg.sv - shared ALU op codes, issue FSM states and sizing helpers
// Purpose: constants and types used by the ALU issue controller, its command FIFO and interface.
// Ports: none (package).
package cpu_alu_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [1:0] ALUC_ADD = 2'b00;
  localparam logic [1:0] ALUC_SUB = 2'b01;
  localparam logic [1:0] ALUC_AND = 2'b10;
  localparam logic [1:0] ALUC_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // One FIFO entry carries {X, Y, Aluc}.
  function automatic int cmd_bits(input int width);
    return 2 * width + 2;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - command, ALU and result signal bundle of the issue controller
// Purpose: groups the command input, ALU operand/result and result output handshakes.
// Ports (slave = controller side):
//   In_Valid/In_Ready/In_X/In_Y/In_Aluc   command stream into the controller
//   Alu_X/Alu_Y/Alu_Aluc, Alu_R/Alu_Z     operands to and result from the ALU
//   Out_Valid/Out_Ready/Out_R/Out_Z       captured result stream
//   Busy, Count                           status
interface alu_issue_ctrl_if
  import cpu_alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 4
);

  logic                       In_Valid;
  logic                       In_Ready;
  logic [WIDTH-1:0]           In_X;
  logic [WIDTH-1:0]           In_Y;
  logic [1:0]                 In_Aluc;
  logic [WIDTH-1:0]           Alu_X;
  logic [WIDTH-1:0]           Alu_Y;
  logic [1:0]                 Alu_Aluc;
  logic [WIDTH-1:0]           Alu_R;
  logic                       Alu_Z;
  logic                       Out_Valid;
  logic                       Out_Ready;
  logic [WIDTH-1:0]           Out_R;
  logic                       Out_Z;
  logic                       Busy;
  logic [$clog2(DEPTH+1)-1:0] Count;

  modport slave (
    input  In_Valid, In_X, In_Y, In_Aluc, Alu_R, Alu_Z, Out_Ready,
    output In_Ready, Alu_X, Alu_Y, Alu_Aluc, Out_Valid, Out_R, Out_Z, Busy, Count
  );

  modport master (
    output In_Valid, In_X, In_Y, In_Aluc, Alu_R, Alu_Z, Out_Ready,
    input  In_Ready, Alu_X, Alu_Y, Alu_Aluc, Out_Valid, Out_R, Out_Z, Busy, Count
  );

endinterface

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - synchronous command FIFO with occupancy count
// Purpose: buffers ALU commands between the command input and the issue FSM.
// Ports:
//   Clk, Clr         clock, asynchronous active-high reset
//   i_push, i_data   write request and entry (ignored while full)
//   i_pop            read request (ignored while empty); o_data shows the head
//   o_full, o_empty  occupancy flags
//   o_count          number of stored entries
module cmd_fifo #(
  parameter  int DW    = 66,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          Clk,
  input  logic          Clr,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage needs no reset; only the pointers and count define validity.
  always_ff @(posedge Clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers are exactly log2(DEPTH) bits so they wrap modulo DEPTH on their own.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issues queued commands to the ALU one at a time and returns results
// Purpose: buffers commands, drives registered Alu_X/Alu_Y/Alu_Aluc, waits LAT cycles,
//          captures Alu_R/Alu_Z and holds them on the result stream until accepted.
// Ports:
//   Clk, Clr   clock, asynchronous active-high reset
//   bus        alu_issue_ctrl_if.slave: command in, ALU operands/result, result out, Busy/Count
module alu_issue_ctrl
  import cpu_alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 4,
  parameter int LAT   = 1
) (
  input logic             Clk,
  input logic             Clr,
  alu_issue_ctrl_if.slave bus
);

  localparam int DW = cmd_bits(WIDTH);
  localparam int LW = $clog2(LAT + 1);
  localparam int CW = $clog2(DEPTH + 1);

  state_t           r_state;
  logic [LW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_alu_x;
  logic [WIDTH-1:0] r_alu_y;
  logic [1:0]       r_alu_aluc;
  logic [WIDTH-1:0] r_out_r;
  logic             r_out_z;
  logic             r_out_valid;

  logic [DW-1:0]    w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic [CW-1:0]    w_count;

  // Out_Valid is always high in HOLD, so Out_Ready alone completes the handshake there.
  assign w_pop = !w_empty && ((r_state == ST_IDLE) || (r_state == ST_HOLD && bus.Out_Ready));

  cmd_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .Clk     (Clk),
    .Clr     (Clr),
    .i_push  (bus.In_Valid),
    .i_data  ({bus.In_X, bus.In_Y, bus.In_Aluc}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_alu_x     <= '0;
      r_alu_y     <= '0;
      r_alu_aluc  <= '0;
      r_out_r     <= '0;
      r_out_z     <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            {r_alu_x, r_alu_y, r_alu_aluc} <= w_head;
            r_cnt   <= LW'(LAT);
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - LW'(1);
          if (r_cnt == LW'(1)) begin
            r_out_r     <= bus.Alu_R;
            r_out_z     <= bus.Alu_Z;
            r_out_valid <= 1'b1;
            r_state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.Out_Ready) begin
            r_out_valid <= 1'b0;
            if (w_pop) begin
              // Back-to-back issue; Alu_* otherwise keep the last command.
              {r_alu_x, r_alu_y, r_alu_aluc} <= w_head;
              r_cnt   <= LW'(LAT);
              r_state <= ST_WAIT;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // In_Ready comes from the registered count, so a pop never raises it within the same cycle.
  assign bus.In_Ready  = !w_full;
  assign bus.Alu_X     = r_alu_x;
  assign bus.Alu_Y     = r_alu_y;
  assign bus.Alu_Aluc  = r_alu_aluc;
  assign bus.Out_Valid = r_out_valid;
  assign bus.Out_R     = r_out_r;
  assign bus.Out_Z     = r_out_z;
  assign bus.Busy      = !w_empty || (r_state != ST_IDLE);
  assign bus.Count     = w_count;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl with a scoreboarded ALU model
module tb_alu_issue_ctrl;
  import cpu_alu_pkg::*;

  localparam int W = 32;
  localparam int D = 4;
  localparam int L = 1;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  logic [W:0]   sb[$];
  int           hs_cyc[$];
  logic [W-1:0] got_r[$];
  logic [W-1:0] stall_r;

  alu_issue_ctrl_if #(.WIDTH(W), .DEPTH(D)) bus ();

  alu_issue_ctrl #(.WIDTH(W), .DEPTH(D), .LAT(L)) dut (
    .Clk (clk),
    .Clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] alu_ref(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [1:0] op);
    case (op)
      ALUC_ADD: return x + y;
      ALUC_SUB: return x - y;
      ALUC_AND: return x & y;
      default:  return x | y;
    endcase
  endfunction

  assign bus.Alu_R = alu_ref(bus.Alu_X, bus.Alu_Y, bus.Alu_Aluc);
  assign bus.Alu_Z = (bus.Alu_R == '0);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds the command until accepted; records the expected result at the accept edge.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] op);
    logic         rdy;
    logic [W-1:0] r;
    bit           done;
    done = 0;
    bus.In_Valid = 1'b1;
    bus.In_X     = x;
    bus.In_Y     = y;
    bus.In_Aluc  = op;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      rdy = bus.In_Ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        r = alu_ref(x, y, op);
        sb.push_back({(r == '0), r});
        done = 1;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $error("FAIL send_timeout observed=stalled expected=accepted");
    end
  endtask

  task automatic drain();
    bit done;
    done = 0;
    bus.In_Valid = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      if (sb.size() == 0 && !bus.Busy && !bus.Out_Valid) done = 1;
      else tick(1);
    end
    if (!done) begin
      checks++;
      failures++;
      $error("FAIL drain_timeout observed=pending%0d expected=0", sb.size());
    end
  endtask

  // Result monitor: a handshake is seen here half a cycle before its accepting edge.
  always @(negedge clk) begin
    logic [W:0] exp;
    if (!clr && bus.Out_Valid && bus.Out_Ready) begin
      hs_cyc.push_back(cyc);
      got_r.push_back(bus.Out_R);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL unexpected_result observed=%0h expected=none", bus.Out_R);
      end else begin
        exp = sb.pop_front();
        check("result_zr", {bus.Out_Z, bus.Out_R}, exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.In_Valid  = 1'b0;
    bus.In_X      = '0;
    bus.In_Y      = '0;
    bus.In_Aluc   = '0;
    bus.Out_Ready = 1'b0;

    // Power-up reset state
    #1;
    check("rst_out_valid", bus.Out_Valid, 0);
    check("rst_count",     bus.Count, 0);
    check("rst_in_ready",  bus.In_Ready, 1);
    check("rst_busy",      bus.Busy, 0);
    check("rst_alu_x",     bus.Alu_X, 0);
    tick(2);
    clr = 1'b0;

    // 1: reset while WAIT with 3 commands queued
    for (int i = 1; i <= 4; i++) send(W'(i), W'(i), ALUC_ADD);
    bus.Out_Ready = 1'b1;
    send(32'd5, 32'd5, ALUC_ADD);
    bus.In_Valid = 1'b0;
    check("t1_count_before", bus.Count, 3);
    check("t1_alu_x_before", bus.Alu_X, 2);
    #1 clr = 1'b1;
    #1;
    check("t1_out_valid", bus.Out_Valid, 0);
    check("t1_count",     bus.Count, 0);
    check("t1_alu_x",     bus.Alu_X, 0);
    check("t1_in_ready",  bus.In_Ready, 1);
    check("t1_busy",      bus.Busy, 0);
    sb.delete();
    tick(2);
    clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("t1_no_result", bus.Out_Valid, 0);
    end

    // 2: single AND, result two edges after the accept edge
    send(32'hC, 32'hA, ALUC_AND);
    bus.In_Valid = 1'b0;
    check("t2_valid_t0", bus.Out_Valid, 0);
    tick(1);
    check("t2_valid_t1", bus.Out_Valid, 0);
    check("t2_alu_x",    bus.Alu_X, 32'hC);
    check("t2_alu_aluc", bus.Alu_Aluc, ALUC_AND);
    tick(1);
    check("t2_valid_t2", bus.Out_Valid, 1);
    check("t2_out_r",    bus.Out_R, 32'h8);
    check("t2_out_z",    bus.Out_Z, 0);
    drain();

    // 3: zero flag
    send(32'h5, 32'h5, ALUC_SUB);
    bus.In_Valid = 1'b0;
    tick(2);
    check("t3_valid", bus.Out_Valid, 1);
    check("t3_out_r", bus.Out_R, 0);
    check("t3_out_z", bus.Out_Z, 1);
    drain();

    // 4: fill and stall
    bus.Out_Ready = 1'b0;
    for (int i = 0; i < 5; i++) send(32'h10 + W'(i), 32'h3, ALUC_ADD);
    check("t4_in_ready_full", bus.In_Ready, 0);
    check("t4_count_full",    bus.Count, 4);
    stall_r = 32'h13;
    bus.In_X = 32'h15;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("t4_stall_valid", bus.Out_Valid, 1);
      check("t4_stall_r",     bus.Out_R, stall_r);
      check("t4_stall_ready", bus.In_Ready, 0);
    end
    bus.Out_Ready = 1'b1;
    send(32'h15, 32'h3, ALUC_ADD);
    drain();

    // 5: back-to-back throughput
    hs_cyc.delete();
    got_r.delete();
    for (int i = 1; i <= 4; i++) send(W'(i), W'(i), ALUC_ADD);
    drain();
    check("t5_n_results", got_r.size(), 4);
    if (got_r.size() == 4) begin
      check("t5_r0", got_r[0], 2);
      check("t5_r1", got_r[1], 4);
      check("t5_r2", got_r[2], 6);
      check("t5_r3", got_r[3], 8);
      for (int i = 1; i < 4; i++) check("t5_spacing", hs_cyc[i] - hs_cyc[i-1], L + 1);
    end

    // 6: same-edge push and pop at Count=2
    bus.Out_Ready = 1'b0;
    send(32'h21, 32'h1, ALUC_SUB);
    send(32'hF0, 32'h0F, ALUC_OR);
    send(32'h7, 32'h9, ALUC_ADD);
    bus.In_Valid = 1'b0;
    check("t6_count_pre", bus.Count, 2);
    bus.Out_Ready = 1'b1;
    send(32'hFF, 32'h3C, ALUC_AND);
    check("t6_count_same_edge", bus.Count, 2);
    drain();

    check("end_pending", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
